// File: rtl/pll_div_pkg.sv
// Shared types and limits for the PLL feedback divider.
package pll_div_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } div_state_t;

    localparam int MIN_DIV = 2;

endpackage

// File: rtl/pll_fb_div.sv
// Programmable feedback divider clocked by the ring oscillator; divides clk by N
// with ratio changes taken only at period boundaries and a clean stop on en low.
module pll_fb_div
    import pll_div_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int DEFAULT_DIV = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] div_ratio,
    input  logic             div_load,
    output logic             div_out,
    output logic             tc,
    output logic             load_ack,
    output logic [WIDTH-1:0] ratio_active,
    output logic             busy,
    output logic             err
);

    div_state_t       state;
    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] pending;
    logic             pending_valid;

    logic             at_end;
    logic             boundary;
    logic             load_ok;
    logic [WIDTH-1:0] high_len;

    // Last count of the period under the ratio that is active right now.
    assign at_end   = (cnt == ratio_active - 1'b1);
    assign boundary = (state == IDLE) || at_end;
    assign load_ok  = div_load && (div_ratio >= WIDTH'(MIN_DIV));
    // ceil(N/2) without widening: odd ratios get the extra cycle in the high phase.
    assign high_len = (ratio_active >> 1) + {{(WIDTH-1){1'b0}}, ratio_active[0]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            cnt           <= '0;
            pending       <= '0;
            pending_valid <= 1'b0;
            ratio_active  <= WIDTH'(DEFAULT_DIV);
            div_out       <= 1'b0;
            tc            <= 1'b0;
            load_ack      <= 1'b0;
            busy          <= 1'b0;
            err           <= 1'b0;
        end else begin
            load_ack <= 1'b0;

            if (boundary && pending_valid) begin
                ratio_active  <= pending;
                pending_valid <= 1'b0;
                load_ack      <= 1'b1;
            end

            // NOTE: the later non-blocking assignment wins, so a load landing on a
            // boundary re-arms pending_valid instead of being consumed by it.
            if (load_ok) begin
                pending       <= div_ratio;
                pending_valid <= 1'b1;
            end
            if (div_load && !load_ok) begin
                err <= 1'b1;
            end

            div_out <= (state != IDLE) && (cnt < high_len);
            tc      <= (state != IDLE) && at_end;

            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (en) begin
                        state <= RUN;
                        busy  <= 1'b1;
                    end
                end
                RUN: begin
                    cnt <= at_end ? '0 : cnt + 1'b1;
                    if (!en) begin
                        if (at_end) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    // Finish the current period so no truncated pulse reaches the PFD.
                    cnt <= at_end ? '0 : cnt + 1'b1;
                    if (en) begin
                        state <= RUN;
                    end else if (at_end) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pll_fb_div.sv
// Self-checking bench for pll_fb_div: period-level reference model compared every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_pll_fb_div;

    localparam int WIDTH       = 8;
    localparam int DEFAULT_DIV = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             en = 1'b0;
    logic [WIDTH-1:0] div_ratio = '0;
    logic             div_load = 1'b0;
    logic             div_out;
    logic             tc;
    logic             load_ack;
    logic [WIDTH-1:0] ratio_active;
    logic             busy;
    logic             err;

    pll_fb_div #(.WIDTH(WIDTH), .DEFAULT_DIV(DEFAULT_DIV)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .en           (en),
        .div_ratio    (div_ratio),
        .div_load     (div_load),
        .div_out      (div_out),
        .tc           (tc),
        .load_ack     (load_ack),
        .ratio_active (ratio_active),
        .busy         (busy),
        .err          (err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Reference model: "active" covers both running and draining; a period
    // position runs 0..N-1 and ratio swaps happen only where a period ends or
    // while stopped.
    bit m_active, m_pv, m_err, m_last, m_ack;
    int m_pos, m_n, m_pend;
    bit e_div, e_tc, e_ack, e_busy, e_err;
    int e_ratio;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_active = 0; m_pv = 0; m_err = 0; m_pos = 0;
            m_n = DEFAULT_DIV; m_pend = 0;
            e_div = 0; e_tc = 0; e_ack = 0; e_busy = 0; e_err = 0;
            e_ratio = DEFAULT_DIV;
        end else begin
            m_last = m_active && (m_pos == m_n - 1);
            e_div  = m_active && (m_pos < (m_n + 1) / 2);
            e_tc   = m_last;
            m_ack  = (!m_active || m_last) && m_pv;
            if (m_active) begin
                m_pos = m_last ? 0 : m_pos + 1;
                if (!en && m_last) m_active = 0;
            end else begin
                m_active = en;
            end
            if (m_ack) begin
                m_n  = m_pend;
                m_pv = 0;
            end
            if (div_load) begin
                if (div_ratio < 2) m_err = 1;
                else begin
                    m_pend = int'(div_ratio);
                    m_pv   = 1;
                end
            end
            e_ack   = m_ack;
            e_busy  = m_active;
            e_ratio = m_n;
            e_err   = m_err;
        end
    end

    always @(negedge clk) begin
        check("div_out", div_out, e_div);
        check("tc", tc, e_tc);
        check("load_ack", load_ack, e_ack);
        check("busy", busy, e_busy);
        check("err", err, e_err);
        check("ratio_active", ratio_active, e_ratio);
    end

    // which: 0 = load_ack, 1 = tc, else div_out. Bounded; a timeout counts as a failure.
    task automatic wait_for(input int which, input int max, input string name);
        int  i = 0;
        bit  seen = 0;
        while (!seen && i < max) begin
            @(negedge clk);
            i++;
            case (which)
                0:       seen = load_ack;
                1:       seen = tc;
                default: seen = div_out;
            endcase
        end
        check(name, seen, 1);
    endtask

    task automatic load(input int value);
        div_ratio = WIDTH'(value);
        div_load  = 1'b1;
        @(negedge clk);
        div_load  = 1'b0;
    endtask

    logic [9:0] bits;
    logic [8:0] busy_bits;
    int         cnt_a;
    logic       prev;

    initial begin
        repeat (2) @(negedge clk);
        check("rst_div_out", div_out, 0);
        check("rst_ratio", ratio_active, DEFAULT_DIV);
        check("rst_busy", busy, 0);
        check("rst_err", err, 0);
        rst_n = 1'b1;

        // Default ratio 4: 1,1,0,0 pattern, one tc per period, f_clk/4.
        @(negedge clk); en = 1'b1;
        @(negedge clk);
        check("start_busy", busy, 1);
        check("start_div_out", div_out, 0);
        bits = '0; cnt_a = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            bits  = {bits[8:0], div_out};
            cnt_a += int'(tc);
        end
        check("n4_pattern", bits[7:0], 8'b1100_1100);
        check("n4_tc_count", cnt_a, 2);
        cnt_a = 0; prev = div_out;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (div_out && !prev) cnt_a++;
            prev = div_out;
        end
        check("n4_rising_edges_40clk", cnt_a, 10);

        // Load 5 at cnt=1: current period completes, then 3 high / 2 low.
        wait_for(1, 8, "align_tc_a");
        @(negedge clk);
        load(5);
        wait_for(0, 8, "ack_n5");
        check("ack_n5_ratio", ratio_active, 5);
        check("ack_n5_with_tc", tc, 1);
        bits = '0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            bits = {bits[8:0], div_out};
        end
        check("n5_pattern", bits, 10'b11100_11100);

        // Illegal ratios 1 and 0: sticky err, nothing applied.
        div_ratio = 8'd1; div_load = 1'b1;
        @(negedge clk); div_ratio = 8'd0;
        @(negedge clk); div_load = 1'b0;
        check("err_set", err, 1);
        cnt_a = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            cnt_a += int'(load_ack);
        end
        check("illegal_no_ack", cnt_a, 0);
        check("illegal_ratio_kept", ratio_active, 5);
        check("err_sticky", err, 1);

        // Two loads before a wrap: only the last one is applied, one ack.
        wait_for(1, 8, "align_tc_b");
        @(negedge clk);
        div_ratio = 8'd6; div_load = 1'b1;
        @(negedge clk); div_ratio = 8'd10;
        @(negedge clk); div_load = 1'b0;
        cnt_a = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            cnt_a += int'(load_ack);
        end
        check("double_load_acks", cnt_a, 1);
        check("double_load_ratio", ratio_active, 10);

        // Load in the wrap cycle: deferred to the following wrap.
        wait_for(1, 12, "align_tc_c");
        repeat (9) @(negedge clk);
        load(7);
        check("wrap_load_no_ack", load_ack, 0);
        check("wrap_load_tc", tc, 1);
        wait_for(0, 15, "wrap_load_late_ack");
        check("wrap_load_ratio", ratio_active, 7);

        // Reloading the active ratio still acknowledges.
        @(negedge clk);
        load(7);
        wait_for(0, 10, "same_ratio_ack");

        // N=8, en dropped at cnt=1: drain the full period, then idle.
        @(negedge clk);
        load(8);
        wait_for(0, 10, "ack_n8");
        @(negedge clk);
        en = 1'b0;
        bits = '0; busy_bits = '0;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            bits      = {bits[8:0], div_out};
            busy_bits = {busy_bits[7:0], busy};
        end
        check("drain_div_out", bits[8:0], 9'b111_000_000);
        check("drain_busy", busy_bits, 9'b111_111_000);

        // Pending ratio applied right away while idle.
        load(3);
        check("idle_no_ack_yet", load_ack, 0);
        @(negedge clk);
        check("idle_ack", load_ack, 1);
        check("idle_ratio", ratio_active, 3);
        check("idle_div_out", div_out, 0);

        // Async reset in the high phase takes effect without a clock edge.
        en = 1'b1;
        wait_for(2, 8, "reach_high");
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_div_out", div_out, 0);
        check("async_rst_ratio", ratio_active, DEFAULT_DIV);
        check("async_rst_busy", busy, 0);
        en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pll_fb_div.md
Name: pll_fb_div

Overview:
- Programmable feedback divider clocked directly by the ring-oscillator output. It sits immediately downstream of the ringosc stage.
- Divides the oscillator clock by N and drives the divided clock to the phase-frequency detector.
- Supports glitch-free ratio changes applied only at period boundaries, and a clean start/stop under enable.
- Target example: at 2.00 GHz oscillator with N=4, div_out = 500 MHz.

Parameters:
- WIDTH, 8, bit width of the divide ratio and internal counter.
- DEFAULT_DIV, 4, ratio loaded at reset; must be in [2, 2^WIDTH-1].

Ports:
- clk  input  1  oscillator clock (ringosc out).
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  run enable, level-sensitive.
- div_ratio  input  WIDTH  requested divide ratio N.
- div_load  input  1  one-cycle request to capture div_ratio.
- div_out  output  1  divided clock, registered.
- tc  output  1  one-cycle pulse on the last clk of each output period.
- load_ack  output  1  one-cycle pulse when a pending ratio becomes active.
- ratio_active  output  WIDTH  ratio currently governing the counter.
- busy  output  1  high in RUN or DRAIN.
- err  output  1  sticky; set by an illegal load request.

Behaviour:
- One clock, clk. Reset is asynchronous, active-low (rst_n). All state is reset asynchronously; outputs are registered.
- Reset values:
  - div_out=0, tc=0, load_ack=0, busy=0, err=0.
  - ratio_active=DEFAULT_DIV.
  - cnt=0, pending_valid=0, state=IDLE.
- Legal ratios are N in [2, 2^WIDTH-1]. On div_load with div_ratio<2:
  - request is ignored;
  - err is set and stays high until rst_n;
  - pending state is unchanged.
- Legal div_load captures div_ratio into pending and sets pending_valid.
  - A later load before application overwrites pending (last write wins).
  - Loading the same value as ratio_active still produces load_ack.
- States: IDLE, RUN, DRAIN.
  - IDLE -> RUN: en=1 sampled.
  - RUN -> DRAIN: en=0 sampled with cnt != N-1.
  - RUN -> IDLE: en=0 sampled with cnt == N-1 (period ends this cycle).
  - DRAIN -> IDLE: when cnt == N-1.
  - DRAIN -> RUN: en re-asserted. The period continues with no phase reset.
- Counter cnt runs 0..N-1 in RUN and DRAIN. It wraps to 0 after N-1.
- div_out is high for cnt < ceil(N/2) and low otherwise.
  - Odd N: high phase is one cycle longer (N=5 gives 3 high, 2 low).
  - div_out reflects the current cnt with one-register latency. With en sampled high at edge k, div_out is 1 after edge k+1.
- tc is high in the cycle where cnt == N-1 (RUN or DRAIN).
- Ratio application at wrap (cnt==N-1 -> 0):
  - If pending_valid, ratio_active <= pending, pending_valid <= 0, load_ack pulses one cycle.
  - The new N governs the very next period. No partial periods ever occur.
- In IDLE:
  - a pending ratio is applied immediately (next clk), with load_ack;
  - cnt is held at 0 and div_out stays 0.
- div_load and wrap in the same cycle: the captured value is NOT applied at this wrap. It becomes pending and is applied at the next wrap.
- Reset mid-period: outputs go to reset values immediately (async). No completion of the period.
- busy = (state != IDLE).

Decomposition:
- Package pll_div_pkg:
  - state enum div_state_t {IDLE, RUN, DRAIN};
  - localparam MIN_DIV = 2.
- Single module, no sub-module. Shadow-register logic is small enough to stay inline.

Test Plan:
- Reset then en=1 with DEFAULT_DIV=4:
  - div_out pattern 1,1,0,0 repeating;
  - tc every 4th clk;
  - measured div_out frequency = f_clk/4 (0.5 GHz at 2 GHz clk).
- Load N=5 mid-period:
  - current 4-cycle period completes;
  - load_ack pulses at the wrap;
  - next periods are 3 high / 2 low;
  - ratio_active=5.
- div_ratio=1 and div_ratio=0 loads:
  - err=1 sticky;
  - ratio_active unchanged;
  - no load_ack;
  - division continues uninterrupted.
- Two loads (N=6 then N=10) before a wrap:
  - only 10 applied;
  - a single load_ack pulse.
- en dropped at cnt=1 with N=8:
  - DRAIN until cnt=7, then IDLE;
  - busy falls;
  - div_out=0;
  - no truncated high pulse.
- rst_n asserted mid-high-phase: div_out=0 and ratio_active=DEFAULT_DIV immediately, without waiting for a clk edge.
